// File: rtl/mem_defs.sv
// Shared encodings for the memory stage: funct3 sizes, FSM states, strobe bases.
// Pure definitions plus a combinational legality helper; no latency or backpressure.
package mem_defs;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] size,
                                        input logic [1:0] lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_B, SZ_BU: ok = 1'b1;
      SZ_H, SZ_HU: ok = ~lo[0];
      SZ_W:        ok = (lo == 2'b00);
      default:     ok = 1'b0;
    endcase
    // Unsigned variants only exist for loads.
    if (is_store && size[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// Load lane select with sign/zero extension; purely combinational, 0 cycles.
// No handshake: output follows the bus word, size and lane directly.
module load_formatter
  import mem_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    data = {{24{byte_sel[7]}}, byte_sel};
      SZ_BU:   data = {24'h000000, byte_sel};
      SZ_H:    data = {{16{half_sel[15]}}, half_sel};
      SZ_HU:   data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/ack data bus access, min 3 cycles (IDLE, BUSY.., DONE).
// Stalls the pipeline while the bus is outstanding; aborts after TIMEOUT_CYCLES without ack.
module mem_access_unit
  import mem_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEMMemRead,
  input  logic        MEMMemWrite,
  input  logic [2:0]  MEMMemSize,
  input  logic [31:0] MEMAluResult,
  input  logic [31:0] MEMStoreData,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWdata,
  output logic [3:0]  BusWstrb,
  input  logic [31:0] BusRdata,
  input  logic        BusAck,
  output logic [31:0] MEMDramData,
  output logic        MemStall,
  output logic        AccessFault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [29:0]   waddr_q, waddr_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   data_q, data_d;
  logic          fault_q, fault_d;

  logic          access;
  logic          legal;
  logic [31:0]   st_wdata;
  logic [3:0]    st_strb;
  logic [31:0]   ld_data;

  load_formatter u_fmt (
    .rdata (BusRdata),
    .size  (size_q),
    .lane  (lane_q),
    .data  (ld_data)
  );

  // Gating with rst_n keeps the combinational stall/fault low while reset is held.
  assign access = (MEMMemRead | MEMMemWrite) & rst_n;
  assign legal  = access_legal(MEMMemWrite, MEMMemSize, MEMAluResult[1:0]);

  always_comb begin
    case (MEMMemSize[1:0])
      2'b00: begin
        st_wdata = {4{MEMStoreData[7:0]}};
        st_strb  = STRB_B << MEMAluResult[1:0];
      end
      2'b01: begin
        st_wdata = {2{MEMStoreData[15:0]}};
        st_strb  = STRB_H << {MEMAluResult[1], 1'b0};
      end
      default: begin
        st_wdata = MEMStoreData;
        st_strb  = STRB_W;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    waddr_d     = waddr_q;
    lane_d      = lane_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    data_d      = data_q;
    fault_d     = fault_q;
    MemStall    = 1'b0;
    AccessFault = 1'b0;
    MEMDramData = data_q;
    case (state_q)
      ST_IDLE: begin
        if (access && legal) begin
          MemStall = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = '0;
          req_d    = 1'b1;
          we_d     = MEMMemWrite;
          waddr_d  = MEMAluResult[31:2];
          lane_d   = MEMAluResult[1:0];
          size_d   = MEMMemSize;
          wdata_d  = MEMMemWrite ? st_wdata : 32'h0;
          strb_d   = MEMMemWrite ? st_strb : 4'h0;
          fault_d  = 1'b0;
        end else if (access) begin
          // Trap unit takes over; the instruction flows on without touching the bus.
          AccessFault = 1'b1;
          MEMDramData = 32'h0;
        end
      end
      ST_BUSY: begin
        MemStall = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (BusAck) begin
          req_d   = 1'b0;
          data_d  = we_q ? 32'h0 : ld_data;
          fault_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          data_d  = 32'h0;
          fault_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        AccessFault = fault_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign BusReq   = req_q;
  assign BusWe    = we_q;
  assign BusAddr  = {waddr_q, 2'b00};
  assign BusWdata = wdata_q;
  assign BusWstrb = strb_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a behavioural memory-stage model.
module tb_mem_access_unit;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEMMemRead, MEMMemWrite;
  logic [2:0]  MEMMemSize;
  logic [31:0] MEMAluResult, MEMStoreData;
  logic        BusReq, BusWe;
  logic [31:0] BusAddr, BusWdata;
  logic [3:0]  BusWstrb;
  logic [31:0] BusRdata;
  logic        BusAck;
  logic [31:0] MEMDramData;
  logic        MemStall, AccessFault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MEMMemRead   (MEMMemRead),
    .MEMMemWrite  (MEMMemWrite),
    .MEMMemSize   (MEMMemSize),
    .MEMAluResult (MEMAluResult),
    .MEMStoreData (MEMStoreData),
    .BusReq       (BusReq),
    .BusWe        (BusWe),
    .BusAddr      (BusAddr),
    .BusWdata     (BusWdata),
    .BusWstrb     (BusWstrb),
    .BusRdata     (BusRdata),
    .BusAck       (BusAck),
    .MEMDramData  (MEMDramData),
    .MemStall     (MemStall),
    .AccessFault  (AccessFault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_nbytes(input logic [2:0] sz);
    return 1 << (int'(sz) % 4);
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] sz, input logic [31:0] a);
    if (we && sz > 3'd2) return 1'b0;
    if (!(sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (a % m_nbytes(sz)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                         input logic [31:0] rd);
    int nb, off;
    logic [31:0] mask, v;
    nb   = m_nbytes(sz);
    off  = a % 4;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    v    = (rd >> (8 * off)) & mask;
    if (sz < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << m_nbytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
    case (m_nbytes(sz))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // One MEM-stage instruction; entered and left just after a rising edge.
  // ack_at = n acks in the n-th BUSY cycle; 0 or > T means never.
  task automatic access(input bit re, input bit we, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int ack_at, input logic [31:0] rd);
    bit acked, done;
    int busy, stalls, exp_busy;
    MEMMemRead   = re;
    MEMMemWrite  = we;
    MEMMemSize   = sz;
    MEMAluResult = a;
    MEMStoreData = sd;
    BusAck       = 1'b0;
    @(negedge clk);
    chk("idle_req", BusReq, 0);
    if (!(re || we)) begin
      chk("nop_stall", MemStall, 0);
      chk("nop_fault", AccessFault, 0);
      @(posedge clk); #1;
      return;
    end
    if (!m_legal(we, sz, a)) begin
      chk("ill_stall", MemStall, 0);
      chk("ill_fault", AccessFault, 1);
      chk("ill_data", MEMDramData, 0);
      @(posedge clk); #1;
      MEMMemRead  = 1'b0;
      MEMMemWrite = 1'b0;
      @(negedge clk);
      chk("ill_fault_pulse", AccessFault, 0);
      chk("ill_noreq", BusReq, 0);
      @(posedge clk); #1;
      return;
    end
    chk("idle_stall", MemStall, 1);
    chk("idle_fault", AccessFault, 0);
    acked    = (ack_at >= 1 && ack_at <= T);
    exp_busy = acked ? ack_at : T;
    stalls   = int'(MemStall);
    busy     = 0;
    done     = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      busy++;
      BusAck   = (busy == ack_at);
      BusRdata = (busy == ack_at) ? rd : $urandom;
      @(negedge clk);
      stalls += int'(MemStall);
      chk("busy_req", BusReq, 1);
      chk("busy_we", BusWe, we);
      chk("busy_addr", BusAddr, a & 32'hFFFF_FFFC);
      chk("busy_strb", BusWstrb, we ? m_strb(sz, a) : 4'h0);
      if (we) chk("busy_wdata", BusWdata, m_wdata(sz, sd));
      if (busy == ack_at || busy == T) done = 1'b1;
    end
    @(posedge clk); #1;
    BusAck   = 1'b0;
    BusRdata = $urandom;
    @(negedge clk);
    stalls += int'(MemStall);
    chk("done_req", BusReq, 0);
    chk("done_data", MEMDramData, (acked && !we) ? m_load(sz, a, rd) : 32'h0);
    chk("done_fault", AccessFault, acked ? 0 : 1);
    chk("stall_cycles", stalls, 1 + exp_busy);
    @(posedge clk); #1;
    MEMMemRead  = 1'b0;
    MEMMemWrite = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    MEMMemRead   = 1'b0;
    MEMMemWrite  = 1'b0;
    MEMMemSize   = 3'b000;
    MEMAluResult = 32'h0;
    MEMStoreData = 32'h0;
    BusRdata     = 32'h0;
    BusAck       = 1'b0;
    #2;
    chk("rst_req", BusReq, 0);
    chk("rst_we", BusWe, 0);
    chk("rst_addr", BusAddr, 0);
    chk("rst_wdata", BusWdata, 0);
    chk("rst_strb", BusWstrb, 0);
    chk("rst_data", MEMDramData, 0);
    chk("rst_fault", AccessFault, 0);
    chk("rst_stall", MemStall, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LB 0x1003, ack in 2nd BUSY cycle
    access(1, 0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h8011_2233);
    chk("lb_value", MEMDramData, 32'hFFFF_FF80);
    // SH 0x2002, immediate ack
    access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h0);
    // LW misaligned
    access(1, 0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'h0);
    // LHU with no ack -> timeout
    access(1, 0, 3'b101, 32'h0000_4002, 32'h0, 0, 32'h0);
    // Back-to-back SW then LBU
    access(0, 1, 3'b010, 32'h0000_0010, 32'h1234_5678, 1, 32'h0);
    access(1, 0, 3'b100, 32'h0000_0013, 32'h0, 1, 32'hAB00_0000);
    chk("lbu_value", MEMDramData, 32'h0000_00AB);
    // Illegal sizes
    access(0, 1, 3'b100, 32'h0000_0020, 32'h0, 1, 32'h0);
    access(1, 0, 3'b111, 32'h0000_0020, 32'h0, 1, 32'h0);

    // Reset in the 2nd BUSY cycle
    MEMMemRead   = 1'b1;
    MEMMemWrite  = 1'b0;
    MEMMemSize   = 3'b010;
    MEMAluResult = 32'h0000_0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", BusReq, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy_req", BusReq, 0);
    chk("rst_busy_stall", MemStall, 0);
    MEMMemRead = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    BusAck   = 1'b1;
    BusRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_ack_req", BusReq, 0);
    chk("late_ack_stall", MemStall, 0);
    @(posedge clk); #1;
    BusAck = 1'b0;
    @(negedge clk);
    chk("late_ack_data", MEMDramData, 0);
    chk("late_ack_fault", AccessFault, 0);
    chk("late_ack_idle", BusReq, 0);
    @(posedge clk); #1;

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      bit re, we;
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      re = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      access(re, we, 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, T + 1), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
